amc13_event_builder: RTL and testbench

- Downstream neighbour of the channel-to-AMC13 transfer manager. Consumes its header/data/trailer word stream and buffers each fill event.
- Forwards an event to the AMC13 link only after the whole event is stored (store-and-forward).
- Replaces the trailer payload with a computed word count and a 32-bit checksum.
- Drives the manager's amc13_rdy/amc13_full flow-control inputs.

---
 rtl/amc13_event_builder.sv | 277 +++++++++++++++++++++++++++
 tb/tb_amc13_event_builder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amc13_event_builder.sv
// Store-and-forward event buffer between the channel-to-AMC13 transfer manager and the AMC13 link.
// Define AMC13_EVB_STATS_EN to add the evt_sent / drop_cnt statistics outputs.
module amc13_event_builder #(
  parameter int ADDR_W    = 9,
  parameter int AF_MARGIN = 16
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [63:0] in_data,
  input  logic        in_header,
  input  logic        in_valid,
  input  logic        in_trailer,
  output logic        amc13_rdy,
  output logic        amc13_full,
  input  logic        link_ready,
  output logic [63:0] link_data,
  output logic        link_valid,
  output logic        link_header,
  output logic        link_trailer,
  output logic        overflow_err,
  output logic        proto_err
`ifdef AMC13_EVB_STATS_EN
  ,
  output logic [31:0] evt_sent,
  output logic [15:0] drop_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_P   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR_W:0] PTR_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_TRL  = 2'b10;

  typedef enum logic {IN_IDLE = 1'b0, IN_EVT = 1'b1} in_state_t;
  typedef enum logic {OUT_IDLE = 1'b0, OUT_SEND = 1'b1} out_state_t;

  function automatic logic [31:0] fold32(input logic [63:0] w);
    return w[63:32] + w[31:0];
  endfunction

  logic [65:0]     mem_r [DEPTH];
  logic [ADDR_W:0] wr_ptr_r, rd_ptr_r, occ_s, occ_nxt_s, events_ready_r;
  logic            full_s, empty_s;
  in_state_t       in_state_r, in_state_s;
  out_state_t      out_state_r, out_state_s;
  logic [31:0]     sum_r, sum_s;
  logic [19:0]     cnt_r, cnt_s;
  logic            skid_v_r, skid_hdr_r, skid_val_r, skid_trl_r;
  logic            skid_v_s, skid_hdr_s, skid_val_s, skid_trl_s;
  logic [63:0]     skid_data_r, skid_data_s;
  logic            cur_hdr_s, cur_val_s, cur_trl_s, cur_any_s, cur_multi_s, in_any_s;
  logic [63:0]     cur_data_s;
  logic            wr_en_s, evt_inc_s, evt_dec_s, proto_set_s, ovf_set_s, drop_s, pop_s;
  logic [65:0]     wr_word_s, rd_word_s;
  logic            amc13_rdy_r, amc13_full_r, overflow_err_r, proto_err_r;
  logic            link_valid_r, link_header_r, link_trailer_r;
  logic [63:0]     link_data_r;

  assign occ_s     = wr_ptr_r - rd_ptr_r;
  assign full_s    = (occ_s == DEPTH_P);
  assign empty_s   = (occ_s == PTR_ZERO);
  assign occ_nxt_s = occ_s + {{ADDR_W{1'b0}}, wr_en_s} - {{ADDR_W{1'b0}}, pop_s};
  assign rd_word_s = mem_r[rd_ptr_r[ADDR_W-1:0]];

  // A held header always goes before the live input word
  assign in_any_s    = in_header | in_valid | in_trailer;
  assign cur_hdr_s   = skid_v_r ? skid_hdr_r  : in_header;
  assign cur_val_s   = skid_v_r ? skid_val_r  : in_valid;
  assign cur_trl_s   = skid_v_r ? skid_trl_r  : in_trailer;
  assign cur_data_s  = skid_v_r ? skid_data_r : in_data;
  assign cur_any_s   = cur_hdr_s | cur_val_s | cur_trl_s;
  assign cur_multi_s = (cur_hdr_s & cur_val_s) | (cur_hdr_s & cur_trl_s) | (cur_val_s & cur_trl_s);

  // Input framing: next state, buffer write word and error/drop events
  always_comb begin
    in_state_s  = in_state_r;
    sum_s       = sum_r;
    cnt_s       = cnt_r;
    wr_en_s     = 1'b0;
    wr_word_s   = 66'd0;
    evt_inc_s   = 1'b0;
    proto_set_s = 1'b0;
    ovf_set_s   = 1'b0;
    drop_s      = 1'b0;
    skid_data_s = skid_data_r;
    skid_hdr_s  = skid_hdr_r;
    skid_val_s  = skid_val_r;
    skid_trl_s  = skid_trl_r;
    if (skid_v_r && in_any_s) begin
      skid_v_s    = 1'b1;
      skid_data_s = in_data;
      skid_hdr_s  = in_header;
      skid_val_s  = in_valid;
      skid_trl_s  = in_trailer;
    end else begin
      skid_v_s = 1'b0;
    end
    if (!cur_any_s) begin
      in_state_s = in_state_r;
    end else if (cur_multi_s) begin
      drop_s      = 1'b1;
      proto_set_s = 1'b1;
    end else begin
      case (in_state_r)
        IN_IDLE: begin
          if (!cur_hdr_s) begin
            drop_s      = 1'b1;
            proto_set_s = 1'b1;
          end else if (full_s) begin
            drop_s    = 1'b1;
            ovf_set_s = 1'b1;
          end else begin
            wr_en_s    = 1'b1;
            wr_word_s  = {TAG_HDR, cur_data_s};
            sum_s      = fold32(cur_data_s);
            cnt_s      = 20'd0;
            in_state_s = IN_EVT;
          end
        end
        IN_EVT: begin
          if (full_s) begin
            drop_s      = 1'b1;
            ovf_set_s   = 1'b1;
            proto_set_s = cur_hdr_s;
          end else if (cur_val_s) begin
            wr_en_s   = 1'b1;
            wr_word_s = {TAG_DATA, cur_data_s};
            sum_s     = sum_r + fold32(cur_data_s);
            if (cnt_r == 20'hFFFFF) begin
              proto_set_s = 1'b1;
            end else begin
              cnt_s = cnt_r + 20'd1;
            end
          end else if (cur_trl_s) begin
            wr_en_s    = 1'b1;
            wr_word_s  = {TAG_TRL, sum_r, 12'h000, cnt_r};
            evt_inc_s  = 1'b1;
            in_state_s = IN_IDLE;
          end else begin
            // Header inside an event: close it now, replay the header next cycle
            proto_set_s = 1'b1;
            wr_en_s     = 1'b1;
            wr_word_s   = {TAG_TRL, sum_r, 12'h000, cnt_r};
            evt_inc_s   = 1'b1;
            in_state_s  = IN_IDLE;
            drop_s      = skid_v_r & in_any_s;
            skid_v_s    = 1'b1;
            skid_data_s = cur_data_s;
            skid_hdr_s  = 1'b1;
            skid_val_s  = 1'b0;
            skid_trl_s  = 1'b0;
          end
        end
        default: in_state_s = IN_IDLE;
      endcase
    end
  end

  // Pop only whole events: either mid-event or with a completed event queued
  assign pop_s     = link_ready & ~empty_s & ((out_state_r == OUT_SEND) | (events_ready_r != PTR_ZERO));
  assign evt_dec_s = pop_s & (rd_word_s[65:64] == TAG_TRL);

  // Output sequencing: next state
  always_comb begin
    out_state_s = out_state_r;
    case (out_state_r)
      OUT_IDLE: begin
        if (pop_s) begin
          out_state_s = evt_dec_s ? OUT_IDLE : OUT_SEND;
        end else if (events_ready_r != PTR_ZERO) begin
          out_state_s = OUT_SEND;
        end else begin
          out_state_s = OUT_IDLE;
        end
      end
      OUT_SEND: begin
        if (evt_dec_s) begin
          out_state_s = OUT_IDLE;
        end else begin
          out_state_s = OUT_SEND;
        end
      end
      default: out_state_s = OUT_IDLE;
    endcase
  end

  // Event storage; contents are meaningless until covered by the pointers
  always_ff @(posedge clk_in) begin
    if (wr_en_s) mem_r[wr_ptr_r[ADDR_W-1:0]] <= wr_word_s;
  end

  // Control state, pointers, flow control, errors and the link output stage
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      in_state_r     <= IN_IDLE;
      out_state_r    <= OUT_IDLE;
      sum_r          <= 32'd0;
      cnt_r          <= 20'd0;
      skid_v_r       <= 1'b0;
      skid_hdr_r     <= 1'b0;
      skid_val_r     <= 1'b0;
      skid_trl_r     <= 1'b0;
      skid_data_r    <= 64'd0;
      wr_ptr_r       <= PTR_ZERO;
      rd_ptr_r       <= PTR_ZERO;
      events_ready_r <= PTR_ZERO;
      amc13_rdy_r    <= 1'b0;
      amc13_full_r   <= 1'b0;
      overflow_err_r <= 1'b0;
      proto_err_r    <= 1'b0;
      link_valid_r   <= 1'b0;
      link_header_r  <= 1'b0;
      link_trailer_r <= 1'b0;
      link_data_r    <= 64'd0;
    end else begin
      in_state_r     <= in_state_s;
      out_state_r    <= out_state_s;
      sum_r          <= sum_s;
      cnt_r          <= cnt_s;
      skid_v_r       <= skid_v_s;
      skid_hdr_r     <= skid_hdr_s;
      skid_val_r     <= skid_val_s;
      skid_trl_r     <= skid_trl_s;
      skid_data_r    <= skid_data_s;
      wr_ptr_r       <= wr_ptr_r + {{ADDR_W{1'b0}}, wr_en_s};
      rd_ptr_r       <= rd_ptr_r + {{ADDR_W{1'b0}}, pop_s};
      case ({evt_inc_s, evt_dec_s})
        2'b10:   events_ready_r <= events_ready_r + PTR_ONE;
        2'b01:   events_ready_r <= events_ready_r - PTR_ONE;
        default: events_ready_r <= events_ready_r;
      endcase
      amc13_rdy_r    <= link_ready;
      amc13_full_r   <= (occ_nxt_s >= AF_THRESH);
      overflow_err_r <= overflow_err_r | ovf_set_s;
      proto_err_r    <= proto_err_r | proto_set_s;
      if (link_ready) begin
        link_valid_r   <= pop_s;
        link_header_r  <= pop_s & (rd_word_s[65:64] == TAG_HDR);
        link_trailer_r <= evt_dec_s;
        link_data_r    <= pop_s ? rd_word_s[63:0] : 64'd0;
      end
    end
  end

  assign amc13_rdy    = amc13_rdy_r;
  assign amc13_full   = amc13_full_r;
  assign overflow_err = overflow_err_r;
  assign proto_err    = proto_err_r;
  assign link_valid   = link_valid_r;
  assign link_header  = link_header_r;
  assign link_trailer = link_trailer_r;
  assign link_data    = link_data_r;

`ifdef AMC13_EVB_STATS_EN
  logic [31:0] evt_sent_r;
  logic [15:0] drop_cnt_r;

  // Sent-event counter wraps, drop counter saturates
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      evt_sent_r <= 32'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      evt_sent_r <= evt_sent_r + {31'd0, evt_dec_s};
      if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

  assign evt_sent = evt_sent_r;
  assign drop_cnt = drop_cnt_r;
`endif

endmodule

// File: tb/tb_amc13_event_builder.sv
// Randomized self-checking bench for amc13_event_builder; expected link streams come from a
// queue-based event model (header, data words, trailer carrying word count and checksum).
module tb_amc13_event_builder;
  localparam int DEPTH     = 512;
  localparam int AF_MARGIN = 16;
  localparam logic [1:0] TAG_DATA = 2'b00;
  localparam logic [1:0] TAG_HDR  = 2'b01;
  localparam logic [1:0] TAG_TRL  = 2'b10;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic        in_header, in_valid, in_trailer;
  logic        amc13_rdy, amc13_full, link_ready;
  logic [63:0] link_data;
  logic        link_valid, link_header, link_trailer, overflow_err, proto_err;
`ifdef AMC13_EVB_STATS_EN
  logic [31:0] evt_sent;
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [65:0] got_q [$];
  logic [65:0] exp_q [$];
  logic [63:0] dbuf  [$];

  always #5 clk_in = ~clk_in;

  amc13_event_builder dut (
    .clk_in(clk_in), .rst(rst), .in_data(in_data), .in_header(in_header),
    .in_valid(in_valid), .in_trailer(in_trailer), .amc13_rdy(amc13_rdy),
    .amc13_full(amc13_full), .link_ready(link_ready), .link_data(link_data),
    .link_valid(link_valid), .link_header(link_header), .link_trailer(link_trailer),
    .overflow_err(overflow_err), .proto_err(proto_err)
`ifdef AMC13_EVB_STATS_EN
    , .evt_sent(evt_sent), .drop_cnt(drop_cnt)
`endif
  );

  // Words actually transferred to the link: valid and ready across the coming edge
  always @(negedge clk_in) begin
    if (!rst && link_valid && link_ready) got_q.push_back({link_trailer, link_header, link_data});
  end

  task automatic drive_word(input logic h, input logic v, input logic t, input logic [63:0] d, input int rmode);
    in_header = h; in_valid = v; in_trailer = t; in_data = d;
    if (rmode == 1) link_ready = 1'($urandom_range(0, 1));
    @(posedge clk_in); #1;
    in_header = 1'b0; in_valid = 1'b0; in_trailer = 1'b0; in_data = 64'd0;
  endtask

  task automatic fill_dbuf(input int n);
    dbuf.delete();
    for (int i = 0; i < n; i++) dbuf.push_back({$urandom, $urandom});
  endtask

  // Drive one event (header, dbuf, trailer) and append its expected link image
  task automatic send_event(input logic [63:0] hdr, input int rmode);
    logic [31:0] s;
    s = hdr[63:32] + hdr[31:0];
    exp_q.push_back({TAG_HDR, hdr});
    drive_word(1'b1, 1'b0, 1'b0, hdr, rmode);
    foreach (dbuf[i]) begin
      s += dbuf[i][63:32] + dbuf[i][31:0];
      exp_q.push_back({TAG_DATA, dbuf[i]});
      drive_word(1'b0, 1'b1, 1'b0, dbuf[i], rmode);
    end
    exp_q.push_back({TAG_TRL, s, 12'h000, 20'(dbuf.size())});
    drive_word(1'b0, 1'b0, 1'b1, {$urandom, $urandom}, rmode);
  endtask

  task automatic drain(input int rmode, input int budget);
    int cyc;
    cyc = 0;
    while (got_q.size() < exp_q.size() && cyc < budget) begin
      link_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk_in); #1;
      cyc++;
    end
    link_ready = 1'b1;
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
    @(posedge clk_in); #1;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    link_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if ({amc13_rdy, amc13_full, link_valid, link_header, link_trailer, overflow_err, proto_err, link_data} !== 71'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {amc13_rdy, amc13_full, link_valid, link_header, link_trailer, overflow_err, proto_err, link_data});
    end
`ifdef AMC13_EVB_STATS_EN
    checks++;
    if ({evt_sent, drop_cnt} !== 48'd0) begin errors++; $display("FAIL reset_stats got %h want 0", {evt_sent, drop_cnt}); end
`endif
    rst = 1'b0;
    @(posedge clk_in); #1;
    checks++;
    if (amc13_rdy !== 1'b1) begin errors++; $display("FAIL rdy_after_reset got %b want 1", amc13_rdy); end
  endtask

  task automatic test_basic();
    link_ready = 1'b1;
    dbuf.delete(); dbuf.push_back(64'h1); dbuf.push_back(64'h2); dbuf.push_back(64'h3);
    send_event(64'h00123456_00000003, 0);
    drain(0, 200);
    checks++;
    if (got_q.size() >= 5 && got_q[4] !== {TAG_TRL, 64'h0012345F_00000003}) begin
      errors++; $display("FAIL basic_trailer got %h want %h", got_q[4], {TAG_TRL, 64'h0012345F_00000003});
    end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_store_forward();
    logic [63:0] hdr;
    logic [31:0] s;
    link_ready = 1'b1;
    hdr = {$urandom, $urandom};
    fill_dbuf(2);
    s = hdr[63:32] + hdr[31:0];
    exp_q.push_back({TAG_HDR, hdr});
    drive_word(1'b1, 1'b0, 1'b0, hdr, 0);
    foreach (dbuf[i]) begin
      s += dbuf[i][63:32] + dbuf[i][31:0];
      exp_q.push_back({TAG_DATA, dbuf[i]});
      drive_word(1'b0, 1'b1, 1'b0, dbuf[i], 0);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_in); #1;
      checks++;
      if (link_valid !== 1'b0) begin errors++; $display("FAIL sf_early_valid cycle %0d got %b want 0", c, link_valid); end
    end
    exp_q.push_back({TAG_TRL, s, 12'h000, 20'd2});
    drive_word(1'b0, 1'b0, 1'b1, {$urandom, $urandom}, 0);
    checks++;
    if (link_valid !== 1'b0) begin errors++; $display("FAIL sf_trailer_cycle got %b want 0", link_valid); end
    @(posedge clk_in); #1;
    checks++;
    if ({link_valid, link_header, link_data} !== {1'b1, 1'b1, hdr}) begin
      errors++; $display("FAIL sf_header got %b%b %h want 11 %h", link_valid, link_header, link_data, hdr);
    end
    drain(0, 200);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sf_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sf_word[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int e = 0; e < 6; e++) begin
      fill_dbuf(int'($urandom_range(0, 12)));
      send_event({$urandom, $urandom}, 1);
      repeat ($urandom_range(0, 3)) begin
        link_ready = 1'($urandom_range(0, 1));
        @(posedge clk_in); #1;
      end
    end
    drain(1, 3000);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_link_stall();
    logic [65:0] snap;
    logic        snap_v;
    link_ready = 1'b0;
    fill_dbuf(6);
    send_event({$urandom, $urandom}, 0);
    for (int c = 0; c < 40; c++) begin
      link_ready = ~link_ready;
      snap   = {link_trailer, link_header, link_data};
      snap_v = link_valid;
      @(posedge clk_in); #1;
      checks++;
      if (amc13_rdy !== link_ready) begin errors++; $display("FAIL stall_rdy cycle %0d got %b want %b", c, amc13_rdy, link_ready); end
      if (!link_ready && snap_v) begin
        checks++;
        if ({link_valid, link_trailer, link_header, link_data} !== {1'b1, snap}) begin
          errors++; $display("FAIL stall_hold cycle %0d got %h want %h", c, {link_trailer, link_header, link_data}, snap);
        end
      end
    end
    drain(0, 200);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_word[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_framing();
    logic [63:0] h1;
    link_ready = 1'b1;
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL frame_clean got %b want 0", proto_err); end
    drive_word(1'b0, 1'b1, 1'b0, {$urandom, $urandom}, 0);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL frame_orphan_data got %b want 1", proto_err); end
    repeat (5) @(posedge clk_in);
    #1;
    checks++;
    if (got_q.size() !== 0) begin errors++; $display("FAIL frame_forwarded got %0d words want 0", got_q.size()); end
    h1 = {$urandom, $urandom};
    exp_q.push_back({TAG_HDR, h1});
    exp_q.push_back({TAG_TRL, h1[63:32] + h1[31:0], 12'h000, 20'd0});
    drive_word(1'b1, 1'b0, 1'b0, h1, 0);
    fill_dbuf(2);
    send_event({$urandom, $urandom}, 0);
    drain(0, 200);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL frame_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_word[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    do_reset();
  endtask

  task automatic test_backpressure();
    logic [63:0] hdr;
    logic [31:0] s;
    int k;
    do_reset();
    link_ready = 1'b0;
    hdr = {$urandom, $urandom};
    fill_dbuf(DEPTH - 2);
    s = hdr[63:32] + hdr[31:0];
    exp_q.push_back({TAG_HDR, hdr});
    drive_word(1'b1, 1'b0, 1'b0, hdr, 0);
    k = 1;
    foreach (dbuf[i]) begin
      s += dbuf[i][63:32] + dbuf[i][31:0];
      exp_q.push_back({TAG_DATA, dbuf[i]});
      drive_word(1'b0, 1'b1, 1'b0, dbuf[i], 0);
      k++;
      checks++;
      if (amc13_full !== (k >= DEPTH - AF_MARGIN)) begin
        errors++; $display("FAIL bp_full occ %0d got %b want %b", k, amc13_full, (k >= DEPTH - AF_MARGIN));
      end
    end
    exp_q.push_back({TAG_TRL, s, 12'h000, 20'(DEPTH - 2)});
    drive_word(1'b0, 1'b0, 1'b1, 64'd0, 0);
    checks++;
    if ({amc13_full, overflow_err} !== 2'b10) begin errors++; $display("FAIL bp_at_depth got %b%b want 10", amc13_full, overflow_err); end
    drive_word(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, 0);
    checks++;
    if (overflow_err !== 1'b1) begin errors++; $display("FAIL bp_overflow got %b want 1", overflow_err); end
`ifdef AMC13_EVB_STATS_EN
    checks++;
    if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop_cnt got %0d want 1", drop_cnt); end
`endif
    drain(0, 2000);
    checks++;
    if (amc13_full !== 1'b0) begin errors++; $display("FAIL bp_full_release got %b want 0", amc13_full); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    link_ready = 1'b1;
    fill_dbuf(2);
    drive_word(1'b1, 1'b0, 1'b0, {$urandom, $urandom}, 0);
    drive_word(1'b0, 1'b1, 1'b0, dbuf[0], 0);
    drive_word(1'b0, 1'b1, 1'b0, dbuf[1], 0);
    rst = 1'b1;
    #2;
    checks++;
    if ({amc13_rdy, amc13_full, link_valid, link_header, link_trailer, overflow_err, proto_err, link_data} !== 71'd0) begin
      errors++; $display("FAIL midrst_outputs got %h want 0", {amc13_rdy, amc13_full, link_valid, link_header, link_trailer, overflow_err, proto_err, link_data});
    end
    @(posedge clk_in); #1;
    rst = 1'b0;
    got_q.delete(); exp_q.delete();
    fill_dbuf(3);
    send_event({$urandom, $urandom}, 0);
    drain(0, 200);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_len got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
`ifdef AMC13_EVB_STATS_EN
    checks++;
    if (evt_sent !== 32'd1) begin errors++; $display("FAIL midrst_evt_sent got %0d want 1", evt_sent); end
`endif
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_data = 64'd0; in_header = 1'b0; in_valid = 1'b0; in_trailer = 1'b0;
    link_ready = 1'b1;
    test_reset();
    test_basic();
    test_store_forward();
    test_random();
    test_link_stall();
    test_framing();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
